// File: rtl/fp_acc_pkg.sv
// Shared types and IEEE-754 single-precision constants for the FP sum accumulator.
package fp_acc_pkg;

    typedef enum logic [2:0] {
        GET    = 3'd0,
        SEND_A = 3'd1,
        SEND_B = 3'd2,
        WAIT_Z = 3'd3,
        CHECK  = 3'd4,
        PUT    = 3'd5
    } acc_state_e;

    localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP_NEG_ZERO = 32'h8000_0000;
    localparam logic [31:0] FP_POS_INF  = 32'h7F80_0000;

endpackage

// File: rtl/fp_sum_accumulator.sv
// Streaming vector-sum controller driving an external FP adder over stb/ack ports.
// FP_ACC_BYPASS_FIRST_EN: first element of each vector loads the accumulator directly.
module fp_sum_accumulator
    import fp_acc_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    input  logic             in_stb,
    output logic             in_ack,
    output logic [31:0]      add_a,
    output logic             add_a_stb,
    input  logic             add_a_ack,
    output logic [31:0]      add_b,
    output logic             add_b_stb,
    input  logic             add_b_ack,
    input  logic [31:0]      add_z,
    input  logic             add_z_stb,
    output logic             add_z_ack,
    output logic [31:0]      sum_z,
    output logic [CNT_W-1:0] sum_cnt,
    output logic             sum_stb,
    input  logic             sum_ack
);

    acc_state_e       state_r;
    logic [31:0]      acc_r;
    logic [31:0]      elem_r;
    logic             last_r;
    logic [CNT_W-1:0] cnt_r;
`ifdef FP_ACC_BYPASS_FIRST_EN
    logic             first_r;
`endif

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + CNT_W'(1'b1);
        end
    endfunction

    // Single FSM: every handshake output is a register set on entry to its state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= GET;
            acc_r     <= FP_POS_ZERO;
            elem_r    <= 32'h0000_0000;
            last_r    <= 1'b0;
            cnt_r     <= '0;
`ifdef FP_ACC_BYPASS_FIRST_EN
            first_r   <= 1'b1;
`endif
            in_ack    <= 1'b0;
            add_a     <= 32'h0000_0000;
            add_a_stb <= 1'b0;
            add_b     <= 32'h0000_0000;
            add_b_stb <= 1'b0;
            add_z_ack <= 1'b0;
            sum_z     <= 32'h0000_0000;
            sum_cnt   <= '0;
            sum_stb   <= 1'b0;
        end else begin
            case (state_r)
                GET: begin
                    if (in_ack && in_stb) begin
                        in_ack <= 1'b0;
                        elem_r <= in_data;
                        last_r <= in_last;
                        cnt_r  <= sat_inc(cnt_r);
`ifdef FP_ACC_BYPASS_FIRST_EN
                        first_r <= 1'b0;
                        if (first_r) begin
                            acc_r   <= in_data;
                            state_r <= CHECK;
                        end else begin
                            add_a     <= acc_r;
                            add_a_stb <= 1'b1;
                            state_r   <= SEND_A;
                        end
`else
                        add_a     <= acc_r;
                        add_a_stb <= 1'b1;
                        state_r   <= SEND_A;
`endif
                    end else begin
                        // Also raises in_ack on the first cycle after reset.
                        in_ack <= 1'b1;
                    end
                end
                SEND_A: begin
                    if (add_a_stb && add_a_ack) begin
                        add_a_stb <= 1'b0;
                        add_b     <= elem_r;
                        add_b_stb <= 1'b1;
                        state_r   <= SEND_B;
                    end
                end
                SEND_B: begin
                    if (add_b_stb && add_b_ack) begin
                        add_b_stb <= 1'b0;
                        add_z_ack <= 1'b1;
                        state_r   <= WAIT_Z;
                    end
                end
                WAIT_Z: begin
                    if (add_z_ack && add_z_stb) begin
                        acc_r     <= add_z;
                        add_z_ack <= 1'b0;
                        state_r   <= CHECK;
                    end
                end
                CHECK: begin
                    if (last_r) begin
                        sum_z   <= acc_r;
                        sum_cnt <= cnt_r;
                        sum_stb <= 1'b1;
                        state_r <= PUT;
                    end else begin
                        in_ack  <= 1'b1;
                        state_r <= GET;
                    end
                end
                PUT: begin
                    if (sum_stb && sum_ack) begin
                        sum_stb <= 1'b0;
                        acc_r   <= FP_POS_ZERO;
                        cnt_r   <= '0;
                        last_r  <= 1'b0;
`ifdef FP_ACC_BYPASS_FIRST_EN
                        first_r <= 1'b1;
`endif
                        in_ack  <= 1'b1;
                        state_r <= GET;
                    end
                end
                default: begin
                    // Unreachable encoding: drop the vector and return to a known idle.
                    acc_r     <= FP_POS_ZERO;
                    cnt_r     <= '0;
                    last_r    <= 1'b0;
`ifdef FP_ACC_BYPASS_FIRST_EN
                    first_r   <= 1'b1;
`endif
                    in_ack    <= 1'b0;
                    add_a_stb <= 1'b0;
                    add_b_stb <= 1'b0;
                    add_z_ack <= 1'b0;
                    sum_stb   <= 1'b0;
                    state_r   <= GET;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_sum_accumulator.sv
// Directed bench for fp_sum_accumulator; the external adder is a lookup of hand-computed sums.
module tb_fp_sum_accumulator;

`ifdef FP_ACC_BYPASS_FIRST_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] in_data = 32'h0;
    logic        in_last = 1'b0;
    logic        in_stb = 1'b0;
    logic        in_ack;
    logic [31:0] add_a;
    logic        add_a_stb;
    logic        add_a_ack = 1'b0;
    logic [31:0] add_b;
    logic        add_b_stb;
    logic        add_b_ack = 1'b0;
    logic [31:0] add_z = 32'h0;
    logic        add_z_stb = 1'b0;
    logic        add_z_ack;
    logic [31:0] sum_z;
    logic [15:0] sum_cnt;
    logic        sum_stb;
    logic        sum_ack = 1'b0;

    int          total = 0;
    int          bad = 0;
    int          passes = 0;
    logic [31:0] acc_m = 32'h0;
    logic [31:0] elem_m = 32'h0;
    int          got;

    fp_sum_accumulator #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_last(in_last), .in_stb(in_stb), .in_ack(in_ack),
        .add_a(add_a), .add_a_stb(add_a_stb), .add_a_ack(add_a_ack),
        .add_b(add_b), .add_b_stb(add_b_stb), .add_b_ack(add_b_ack),
        .add_z(add_z), .add_z_stb(add_z_stb), .add_z_ack(add_z_ack),
        .sum_z(sum_z), .sum_cnt(sum_cnt), .sum_stb(sum_stb), .sum_ack(sum_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h0000_0000, 32'h3F80_0000}: return 32'h3F80_0000;
            {32'h3F80_0000, 32'h4000_0000}: return 32'h4040_0000;
            {32'h4040_0000, 32'h4040_0000}: return 32'h40C0_0000;
            {32'h0000_0000, 32'h8000_0000}: return 32'h0000_0000;
            {32'h0000_0000, 32'h7F80_0000}: return 32'h7F80_0000;
            {32'h7F80_0000, 32'h3F80_0000}: return 32'h7F80_0000;
            {32'h0000_0000, 32'h4000_0000}: return 32'h4000_0000;
            default:                        return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic l);
        int n;
        in_data = d;
        in_last = l;
        in_stb  = 1'b1;
        n = 0;
        while (in_ack !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        got = (in_ack === 1'b1) ? 1 : 0;
        check("push_ready", got, 32'd1);
        @(negedge clk);
        in_stb  = 1'b0;
        in_last = 1'b0;
        elem_m  = d;
    endtask

    task automatic adder_pass(input int a_hold, input bit finish_z);
        check("add_a", add_a, acc_m);
        for (int i = 0; i < a_hold; i++) begin
            @(negedge clk);
            check("add_a_stb_hold", {31'd0, add_a_stb}, 32'd1);
            check("add_a_hold", add_a, acc_m);
        end
        add_a_ack = 1'b1;
        @(negedge clk);
        add_a_ack = 1'b0;
        check("add_b_stb_rise", {30'd0, add_a_stb, add_b_stb}, 32'd1);
        check("add_b", add_b, elem_m);
        add_b_ack = 1'b1;
        @(negedge clk);
        add_b_ack = 1'b0;
        check("add_z_ack", {30'd0, add_b_stb, add_z_ack}, 32'd1);
        if (finish_z) begin
            add_z     = fadd(acc_m, elem_m);
            add_z_stb = 1'b1;
            @(negedge clk);
            add_z_stb = 1'b0;
            acc_m     = add_z;
            passes++;
            check("check_idle", {27'd0, in_ack, add_a_stb, add_b_stb, add_z_ack, sum_stb}, 32'd0);
        end
    endtask

    // One element: an adder pass when the DUT asks for one, otherwise a direct load.
    task automatic element(input logic [31:0] d, input logic l, input int a_hold);
        push(d, l);
        if (add_a_stb === 1'b1) begin
            adder_pass(a_hold, 1'b1);
        end else begin
            acc_m = d;
        end
    endtask

    task automatic get_sum(input logic [31:0] ez, input logic [31:0] ecnt, input int hold);
        int n;
        n = 0;
        while (sum_stb !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        got = (sum_stb === 1'b1) ? 1 : 0;
        check("sum_stb", got, 32'd1);
        check("sum_z", sum_z, ez);
        check("sum_cnt", {16'd0, sum_cnt}, ecnt);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("sum_hold_stb_inack", {30'd0, sum_stb, in_ack}, 32'd2);
            check("sum_hold_z", sum_z, ez);
            check("sum_hold_cnt", {16'd0, sum_cnt}, ecnt);
        end
        sum_ack = 1'b1;
        @(negedge clk);
        sum_ack = 1'b0;
        check("after_put", {30'd0, sum_stb, in_ack}, 32'd1);
        acc_m = 32'h0;
    endtask

    initial begin
        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_hs", {27'd0, in_ack, add_a_stb, add_b_stb, add_z_ack, sum_stb}, 32'd0);
        check("rst_sum_z", sum_z, 32'h0);
        check("rst_sum_cnt", {16'd0, sum_cnt}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("get_in_ack", {31'd0, in_ack}, 32'd1);

        // 1.0 + 2.0 + 3.0, stalled a-port on the second element, stalled sum.
        passes = 0;
        element(32'h3F80_0000, 1'b0, 0);
        element(32'h4000_0000, 1'b0, 5);
        element(32'h4040_0000, 1'b1, 0);
        get_sum(32'h40C0_0000, 32'd3, 10);
        check("v1_passes", passes, BYPASS ? 32'd2 : 32'd3);

        // Lone -0.0, issued back-to-back with the previous vector.
        passes = 0;
        element(32'h8000_0000, 1'b1, 0);
        get_sum(BYPASS ? 32'h8000_0000 : 32'h0000_0000, 32'd1, 0);
        check("v2_passes", passes, BYPASS ? 32'd0 : 32'd1);

        // +Inf propagates through accumulation.
        passes = 0;
        element(32'h7F80_0000, 1'b0, 0);
        element(32'h3F80_0000, 1'b1, 2);
        get_sum(32'h7F80_0000, 32'd2, 1);
        check("v3_passes", passes, BYPASS ? 32'd1 : 32'd2);

        // Reset while waiting on the second element's adder result.
        element(32'h3F80_0000, 1'b0, 0);
        push(32'h4000_0000, 1'b0);
        adder_pass(0, 1'b0);
        rst = 1'b0;
        #1;
        check("midrst_hs", {27'd0, in_ack, add_a_stb, add_b_stb, add_z_ack, sum_stb}, 32'd0);
        check("midrst_sum_z", sum_z, 32'h0);
        check("midrst_add_ab", add_a | add_b, 32'h0);
        @(negedge clk);
        rst   = 1'b1;
        acc_m = 32'h0;
        @(negedge clk);
        check("postrst_in_ack", {31'd0, in_ack}, 32'd1);
        passes = 0;
        element(32'h4000_0000, 1'b1, 0);
        get_sum(32'h4000_0000, 32'd1, 0);
        check("v5_passes", passes, BYPASS ? 32'd0 : 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
